dqm_framer: RTL and testbench
=============================

Name: dqm_framer

Overview:
- Parametrised next-generation data-quality-metric framer.
- Buffers a decoder output bitstream in an internal single-clock FIFO.
- Per frame: emits a configurable header (NUM_HDR words of HDR_W bits), then exactly block_size payload bits, MSB first, with a gate qualifier and a frame-start interrupt.
- Unlike the previous generation, a frame starts only when a whole block is buffered, so there is no mid-frame underrun. Overflow is detected and reported.

Parameters:
- HDR_W, 16, bits per header word
- NUM_HDR, 3, header words per frame (1..8)
- FIFO_DEPTH, 4096, payload FIFO depth in bits (power of 2)
- CNT_W, 16, width of block_size and internal bit counters

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bit_in_valid  in  1  write strobe for bit_in
- bit_in  in  1  payload bit from decoder
- enable  in  1  framer enable; sampled only in IDLE
- block_size  in  CNT_W  payload bits per frame; sampled at frame start
- hdr_words  in  NUM_HDR*HDR_W  header; word 0 in the MSBs; sampled at frame start
- clr_overflow  in  1  clears the overflow flag
- serial_out  out  1  framed serial data, registered
- gate  out  1  high while serial_out carries a header or payload bit
- frame_start  out  1  one-cycle interrupt pulse
- overflow  out  1  sticky FIFO-overflow flag
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bits currently buffered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO emptied; state=IDLE; counters cleared.
  - serial_out=0, gate=0, frame_start=0, overflow=0, fifo_level=0.
  - Reset mid-frame aborts the frame immediately. After release, framing restarts cleanly from IDLE.
- FIFO write:
  - Push when bit_in_valid && !full.
  - bit_in_valid while full: bit dropped and overflow set, unless a pop occurs in the same cycle; then the push is accepted.
  - Push and pop in the same cycle leave fifo_level unchanged.
- State machine IDLE -> HDR -> PAYLOAD -> IDLE:
  - IDLE -> HDR requires enable=1, block_size!=0, block_size<=FIFO_DEPTH and fifo_level>=block_size.
  - On that transition: latch hdr_words into the header shift register and block_size into bs_q; clear the bit counter.
  - HDR: shift one header bit per cycle for NUM_HDR*HDR_W cycles, then go to PAYLOAD.
  - PAYLOAD: pop one FIFO bit per cycle for bs_q cycles, then go to IDLE. A buffered block is guaranteed, so no underrun check is needed.
  - Back-to-back frames: from IDLE, the next HDR can start the cycle after PAYLOAD ends, giving one idle cycle between frames (gate low for 1 cycle).
  - enable deasserted mid-frame: the current frame completes; no new frame starts.
  - block_size or hdr_words changing mid-frame has no effect until the next frame.
- Output timing:
  - serial_out, gate and frame_start are registered, 1-cycle latency from the state or shift decision.
  - FIFO read data is first-word-fall-through, so the payload bit is valid the same cycle as the pop.
  - frame_start is high exactly in the cycle serial_out carries header bit 0 (the MSB of word 0).
  - gate is high for NUM_HDR*HDR_W+bs_q contiguous cycles per frame. serial_out=0 while gate is low.
- overflow:
  - Set on a dropped bit; held until clr_overflow.
  - If a drop and clr_overflow occur in the same cycle, set wins.
- Counters wrap only through explicit clear; bs_q up to 2^CNT_W-1 is supported, limited by FIFO_DEPTH.

Optional Feature:
- Macro: DQM_FRAMER_CRC_EN.
- Defined:
  - Adds a CRC state after PAYLOAD.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is computed over the payload bits only.
  - The 16-bit CRC is emitted MSB first with gate high, so gate length becomes NUM_HDR*HDR_W+bs_q+16.
- Undefined: no CRC state and no CRC logic; the frame ends after the payload.

Decomposition:
- Package dqm_pkg:
  - state enum (IDLE, HDR, PAYLOAD, CRC)
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF
  - function clog2-based level width
- Sub-module dqm_sync_fifo: 1-bit wide, FIFO_DEPTH deep, single clock, asynchronous active-low reset, first-word-fall-through, with full, empty and level outputs.
- Framer FSM, shifter and output registers live in dqm_framer.

Test Plan:
- Basic frame: defaults, block_size=8, hdr=0xA5A5/0x0F0F/0x1234, push 8 bits 10110010, enable=1 -> one frame_start pulse; serial_out = 48 header bits then 10110010; gate high for 56 cycles.
- Block gating: block_size=16, push 15 bits -> gate stays 0 indefinitely; push a 16th bit -> frame starts within 2 cycles.
- Overflow: FIFO_DEPTH=64, enable=0, push 70 bits -> fifo_level=64, overflow=1; clr_overflow -> 0; clr_overflow together with a further push at full -> overflow stays 1.
- Mid-frame changes: change hdr_words and block_size, and deassert enable, during PAYLOAD -> current frame unchanged; no next frame.
- Reset mid-frame: pulse rst_n low during HDR -> outputs 0 and fifo_level=0 asynchronously; after release, a fresh 8-bit block produces a correct full frame.
- CRC (DQM_FRAMER_CRC_EN): payload ASCII "123456789" (72 bits), block_size=72 -> trailer 0x29B1; gate length 48+72+16=136.

Source files
------------

// File: rtl/dqm_pkg.sv
// dqm_pkg: shared types and constants for the dqm_framer slice.
//   state_t       framer FSM states
//   CRC16_POLY    CRC-16-CCITT polynomial
//   CRC16_INIT    CRC-16-CCITT seed
//   lvl_w()       width of a 0..depth occupancy count
//   crc16_step()  one-bit MSB-first CRC-16 update
package dqm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/dqm_sync_fifo.sv
// dqm_sync_fifo: 1-bit wide, DEPTH deep single-clock FIFO, first-word-fall-through.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        push request (accepted when not full, or when full with a pop)
//   wr_data      bit to push
//   rd_en        pop request (ignored when empty)
//   rd_data      head of FIFO, valid whenever not empty
//   full, empty  occupancy flags
//   level        bits currently stored
module dqm_sync_fifo
  import dqm_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic                      wr_data,
  input  logic                      rd_en,
  output logic                      rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = rd_en && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/dqm_framer.sv
// dqm_framer: buffers a decoder bitstream and emits header + block_size payload
// bits per frame, MSB first, once a whole block is buffered.
// Optional macro DQM_FRAMER_CRC_EN appends a CRC-16-CCITT trailer over the payload.
//   clk, rst_n     clock, asynchronous active-low reset
//   bit_in_valid   write strobe for bit_in
//   bit_in         payload bit
//   enable         framer enable, sampled in IDLE
//   block_size     payload bits per frame, sampled at frame start
//   hdr_words      header, word 0 in the MSBs, sampled at frame start
//   clr_overflow   clears overflow
//   serial_out     framed serial data (registered)
//   gate           high while serial_out carries a frame bit
//   frame_start    one-cycle pulse with header bit 0
//   overflow       sticky FIFO-overflow flag
//   fifo_level     bits buffered
module dqm_framer
  import dqm_pkg::*;
#(
  parameter int HDR_W      = 16,
  parameter int NUM_HDR    = 3,
  parameter int FIFO_DEPTH = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bit_in_valid,
  input  logic                           bit_in,
  input  logic                           enable,
  input  logic [CNT_W-1:0]               block_size,
  input  logic [NUM_HDR*HDR_W-1:0]       hdr_words,
  input  logic                           clr_overflow,
  output logic                           serial_out,
  output logic                           gate,
  output logic                           frame_start,
  output logic                           overflow,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   fifo_level
);

  localparam int HW = NUM_HDR * HDR_W;

  state_t           state_q, state_d;
  logic [HW-1:0]    hdr_q, hdr_d;
  logic [CNT_W-1:0] bs_q, bs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_d, gate_d, fs_d;
  logic             pop, pop_ok, full, empty, rd_data, start_ok, drop;
`ifdef DQM_FRAMER_CRC_EN
  logic [15:0]      crc_q, crc_d;
`endif

  dqm_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bit_in_valid),
    .wr_data (bit_in),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign pop_ok   = pop && !empty;
  assign drop     = bit_in_valid && full && !pop_ok;
  assign start_ok = enable && (block_size != '0)
                 && (32'(block_size) <= 32'(FIFO_DEPTH))
                 && (32'(fifo_level) >= 32'(block_size));

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    bs_d    = bs_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    gate_d  = 1'b0;
    fs_d    = 1'b0;
    pop     = 1'b0;
`ifdef DQM_FRAMER_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = HDR;
          hdr_d   = hdr_words;
          bs_d    = block_size;
          cnt_d   = '0;
`ifdef DQM_FRAMER_CRC_EN
          crc_d   = CRC16_INIT;
`endif
        end
      end
      HDR: begin
        ser_d  = hdr_q[HW-1];
        gate_d = 1'b1;
        fs_d   = (cnt_q == '0);
        hdr_d  = hdr_q << 1;
        if (cnt_q == CNT_W'(HW - 1)) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PAYLOAD: begin
        // FWFT head is the bit being popped this cycle
        pop    = 1'b1;
        ser_d  = rd_data;
        gate_d = 1'b1;
`ifdef DQM_FRAMER_CRC_EN
        crc_d  = crc16_step(crc_q, rd_data);
`endif
        if (cnt_q == bs_q - CNT_W'(1)) begin
          cnt_d = '0;
`ifdef DQM_FRAMER_CRC_EN
          state_d = CRC;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef DQM_FRAMER_CRC_EN
      CRC: begin
        ser_d  = crc_q[15];
        gate_d = 1'b1;
        crc_d  = crc_q << 1;
        if (cnt_q == CNT_W'(15)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      bs_q        <= '0;
      cnt_q       <= '0;
      serial_out  <= 1'b0;
      gate        <= 1'b0;
      frame_start <= 1'b0;
`ifdef DQM_FRAMER_CRC_EN
      crc_q       <= CRC16_INIT;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      bs_q        <= bs_d;
      cnt_q       <= cnt_d;
      serial_out  <= ser_d;
      gate        <= gate_d;
      frame_start <= fs_d;
`ifdef DQM_FRAMER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_dqm_framer.sv
`timescale 1ns/1ps
module tb_dqm_framer;

  localparam int HDR_W   = 16;
  localparam int NUM_HDR = 3;
  localparam int DEPTH   = 128;
  localparam int CNT_W   = 16;
  localparam int HW      = HDR_W * NUM_HDR;
  localparam int LW      = $clog2(DEPTH) + 1;
`ifdef DQM_FRAMER_CRC_EN
  localparam int CRC_LEN = 16;
`else
  localparam int CRC_LEN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_in_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             enable = 1'b0;
  logic             clr_overflow = 1'b0;
  logic [CNT_W-1:0] block_size = '0;
  logic [HW-1:0]    hdr_words = '0;
  logic             serial_out, gate, frame_start, overflow;
  logic [LW-1:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  // reference model: FIFO contents not yet claimed by a frame, true occupancy, overflow flag
  bit q[$];
  int occ = 0;
  bit ovf_m = 1'b0;

  always #5 clk = ~clk;

  dqm_framer #(
    .HDR_W(HDR_W), .NUM_HDR(NUM_HDR), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_in_valid(bit_in_valid), .bit_in(bit_in),
    .enable(enable), .block_size(block_size), .hdr_words(hdr_words),
    .clr_overflow(clr_overflow), .serial_out(serial_out), .gate(gate),
    .frame_start(frame_start), .overflow(overflow), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
    logic [15:0] n;
    n = c << 1;
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  // only while the DUT is not popping
  task automatic push_bit(input bit b);
    bit_in_valid = 1'b1;
    bit_in = b;
    if (occ < DEPTH) begin q.push_back(b); occ++; end
    else ovf_m = 1'b1;
    tick();
    bit_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; bit_in_valid = 1'b0; enable = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    q.delete(); occ = 0; ovf_m = 1'b0;
  endtask

  task automatic idle_check(input int cycles, input string name);
    int g;
    g = 0;
    repeat (cycles) begin
      tick();
      if (gate !== 1'b0 || serial_out !== 1'b0) g++;
    end
    chk(name, g, 0);
  endtask

  // Waits up to budget cycles for frame_start, then checks every frame cycle
  // against the sequence built from the header and the model queue.
  task automatic expect_frame(input logic [HW-1:0] hdr, input int bs, input int budget,
                              input bit push_mode, input bit mid_change,
                              output int glen, output logic [15:0] tail);
    bit eb[$];
    int kd[$];
    logic [15:0] crc;
    bit found, b;
    int n;
    crc = 16'hFFFF; found = 1'b0; glen = 0; tail = '0;
    for (int i = 0; i < HW; i++) begin eb.push_back(hdr[HW-1-i]); kd.push_back(0); end
    for (int i = 0; i < bs; i++) begin
      b = q.pop_front(); eb.push_back(b); kd.push_back(1); crc = crc_step(crc, b);
    end
    for (int i = 0; i < CRC_LEN; i++) begin eb.push_back(crc[15-i]); kd.push_back(2); end
    for (int t = 0; t < budget && !found; t++) begin
      tick();
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk("start_within_budget", found, 1);
    if (!found) return;
    n = eb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      bit_in_valid = 1'b0;
      if (kd[i] == 1) occ--;
      if (mid_change && i == HW) begin
        enable = 1'b0; block_size = CNT_W'(4); hdr_words = ~hdr;
      end
      chk("frame_bit", {frame_start, gate, serial_out}, {(i == 0), 1'b1, eb[i]});
      chk("level_in_frame", fifo_level, occ);
      if (gate === 1'b1) glen++;
      tail = {tail[14:0], serial_out};
      if (push_mode) begin
        b = 1'($urandom);
        bit_in_valid = 1'b1; bit_in = b;
        // accepted if room, or if the next edge pops
        if (occ < DEPTH || (i + 1 < n && kd[i+1] == 1)) begin q.push_back(b); occ++; end
        else ovf_m = 1'b1;
      end
    end
    tick();
    bit_in_valid = 1'b0;
    chk("gap_after_frame", {frame_start, gate, serial_out}, 3'b000);
    if (gate === 1'b1) glen++;
    chk("level_after_frame", fifo_level, occ);
  endtask

  typedef struct {
    int            bs;
    logic [HW-1:0] hdr;
    logic [63:0]   pat;
    int            npush;
    bit            en;
    bit            exp_frame;
    int            glen;
  } vec_t;

  vec_t        vt[6];
  int          glen, bs_r, found;
  logic [HW-1:0] h;
  logic [15:0] tail;
  logic [71:0] msg;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8,   48'hA5A5_0F0F_1234, 64'hB2,                  8,  1'b1, 1'b1, HW + 8 + CRC_LEN};
    vt[1] = '{1,   48'hFFFF_0000_8001, 64'h1,                   1,  1'b1, 1'b1, HW + 1 + CRC_LEN};
    vt[2] = '{64,  48'h0123_4567_89AB, 64'hDEAD_BEEF_0BAD_F00D, 64, 1'b1, 1'b1, HW + 64 + CRC_LEN};
    vt[3] = '{0,   48'h1111_2222_3333, 64'hF,                   4,  1'b1, 1'b0, 0};
    vt[4] = '{8,   48'h4444_5555_6666, 64'hFF,                  8,  1'b0, 1'b0, 0};
    vt[5] = '{200, 48'h7777_8888_9999, 64'h5555_AAAA_5555_AAAA, 64, 1'b1, 1'b0, 0};

    // reset values
    tick();
    chk("rst_serial_out", serial_out, 0);
    chk("rst_gate", gate, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_level", fifo_level, 0);
    rst_n = 1'b1;

    // table-driven frames and no-start conditions
    foreach (vt[k]) begin
      do_reset();
      for (int i = 0; i < vt[k].npush; i++) push_bit(vt[k].pat[vt[k].npush-1-i]);
      hdr_words = vt[k].hdr; block_size = CNT_W'(vt[k].bs); enable = vt[k].en;
      if (vt[k].exp_frame) begin
        expect_frame(vt[k].hdr, vt[k].bs, 4, 1'b0, 1'b0, glen, tail);
        chk("gate_len", glen, vt[k].glen);
      end else begin
        idle_check(30, "no_frame_gate");
        chk("level_kept", fifo_level, occ);
      end
      enable = 1'b0;
    end

    // block gating: one bit short never starts
    do_reset();
    block_size = CNT_W'(16); hdr_words = 48'hBEEF_CAFE_0001; enable = 1'b1;
    for (int i = 0; i < 15; i++) push_bit(1'($urandom));
    idle_check(30, "short_block_gate");
    chk("short_block_level", fifo_level, 15);
    push_bit(1'b1);
    expect_frame(48'hBEEF_CAFE_0001, 16, 3, 1'b0, 1'b0, glen, tail);
    enable = 1'b0;

    // overflow, clear, clear-vs-drop, push while full with pop
    do_reset();
    for (int i = 0; i < DEPTH + 6; i++) push_bit(1'($urandom));
    chk("ovf_level_full", fifo_level, DEPTH);
    chk("ovf_set", overflow, ovf_m);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0; ovf_m = 1'b0;
    chk("ovf_cleared", overflow, 0);
    clr_overflow = 1'b1; push_bit(1'b1); clr_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    ovf_m = 1'b1;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0; ovf_m = 1'b0;
    h = 48'hC3C3_3C3C_F00F;
    hdr_words = h; block_size = CNT_W'(DEPTH); enable = 1'b1;
    expect_frame(h, DEPTH, 4, 1'b1, 1'b0, glen, tail);
    chk("ovf_during_frame", overflow, ovf_m);
    expect_frame(h, DEPTH, 1, 1'b0, 1'b0, glen, tail);
    chk("b2b_gate_len", glen, HW + DEPTH + CRC_LEN);
    enable = 1'b0;

    // mid-frame changes are ignored; enable drop stops after this frame
    do_reset();
    for (int i = 0; i < 24; i++) push_bit(1'($urandom));
    h = 48'h1357_9BDF_2468;
    hdr_words = h; block_size = CNT_W'(8); enable = 1'b1;
    expect_frame(h, 8, 4, 1'b0, 1'b1, glen, tail);
    chk("mid_change_gate_len", glen, HW + 8 + CRC_LEN);
    idle_check(30, "no_frame_after_disable");
    chk("mid_change_level", fifo_level, 16);
    enable = 1'b1;
    expect_frame(~h, 4, 4, 1'b0, 1'b0, glen, tail);
    enable = 1'b0;

    // asynchronous reset during the header
    do_reset();
    for (int i = 0; i < 8; i++) push_bit(1'($urandom));
    h = 48'h0F1E_2D3C_4B5A;
    hdr_words = h; block_size = CNT_W'(8); enable = 1'b1;
    found = 0;
    for (int t = 0; t < 6 && found == 0; t++) begin
      tick();
      if (frame_start === 1'b1) found = 1;
    end
    chk("pre_reset_start", found, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_serial", serial_out, 0);
    chk("async_rst_gate", gate, 0);
    chk("async_rst_fs", frame_start, 0);
    chk("async_rst_level", fifo_level, 0);
    tick();
    rst_n = 1'b1;
    q.delete(); occ = 0; ovf_m = 1'b0;
    for (int i = 0; i < 8; i++) push_bit(1'($urandom));
    expect_frame(h, 8, 4, 1'b0, 1'b0, glen, tail);
    chk("post_reset_gate_len", glen, HW + 8 + CRC_LEN);
    enable = 1'b0;

    // randomized back-to-back frames
    do_reset();
    for (int r = 0; r < 6; r++) begin
      bs_r = $urandom_range(1, 40);
      h = HW'({$urandom, $urandom});
      block_size = CNT_W'(bs_r); hdr_words = h;
      for (int i = 0; i < 2 * bs_r; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        push_bit(1'($urandom));
      end
      enable = 1'b1;
      expect_frame(h, bs_r, 4, 1'b0, 1'b0, glen, tail);
      chk("rand_gate_len", glen, HW + bs_r + CRC_LEN);
      expect_frame(h, bs_r, 1, 1'b0, 1'b0, glen, tail);
      chk("rand_b2b_gate_len", glen, HW + bs_r + CRC_LEN);
      enable = 1'b0;
    end

`ifdef DQM_FRAMER_CRC_EN
    do_reset();
    msg = "123456789";
    for (int i = 0; i < 72; i++) push_bit(msg[71-i]);
    h = 48'hA5A5_0F0F_1234;
    hdr_words = h; block_size = CNT_W'(72); enable = 1'b1;
    expect_frame(h, 72, 4, 1'b0, 1'b0, glen, tail);
    chk("crc_trailer", tail, 16'h29B1);
    chk("crc_gate_len", glen, 136);
    enable = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
